inst_loader: RTL and testbench

Byte-stream program loader that writes 32-bit instruction words into the instruction memory feeding the fetch stage of the 5-stage forwarding pipeline. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake, assembles words, and issues single-cycle memory writes at sequential addresses. It holds the pipeline (`cpu_hold`) for the whole load, so fetch never reads a partially written program.

---
 rtl/inst_loader_if.sv | 22 ++
 rtl/inst_loader.sv | 143 ++++++++++++++
 tb/tb_inst_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Byte-stream and instruction-memory write bus for inst_loader.
// master: byte source / memory sink side. slave: the loader.
//   byte_valid/byte_in/byte_ready : length-prefixed big-endian byte stream
//   wr_en/wr_addr/wr_data         : single-cycle instruction memory write
interface inst_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output byte_valid, byte_in,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_in,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/inst_loader.sv
// Program loader: accepts a 16-bit length N followed by N big-endian 32-bit
// words, writes them to instruction memory at BASE_ADDR+index, and holds the
// CPU while loading.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a load (honoured only in IDLE/DONE/ERR)
//   bus        : byte stream in, memory write strobe/address/data out
//   cpu_hold   : stall fetch while a load is in progress
//   done / err : level status of the last load (ok / length > DEPTH)
module inst_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        byte_ready_q, byte_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;

  // byte_ready_q is itself a decode of the registered state
  assign accept = bus.byte_valid && byte_ready_q;

  // Next-state and next-output logic; outputs are decoded from state_d so
  // they are valid as flops in the cycle the new state is entered.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          idx_d   = 16'd0;
          cnt_d   = 2'd0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = {bus.byte_in, len_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = {len_q[15:8], bus.byte_in};
          if (len_d == 16'd0)                 state_d = DONE;
          else if ({1'b0, len_d} > DEPTH_W)   state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], bus.byte_in};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_ADDR + idx_q;
            wr_data_d = word_d;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == len_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
    cpu_hold_d   = byte_ready_d || (state_d == WRITE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      cnt_q        <= 2'd0;
      word_q       <= 32'd0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 32'd0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: two instances (BASE_ADDR 0x0000 and 0xFFFF) see
// the same stimulus; expected writes are queued per instance as each word is
// driven and popped when the instance strobes wr_en.
module tb_inst_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold_b, done_b, err_b;
  logic cpu_hold_w, done_w, err_w;

  inst_loader_if bif ();
  inst_loader_if wif ();

  inst_loader #(.BASE_ADDR(16'h0000), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bif),
    .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b)
  );

  inst_loader #(.BASE_ADDR(16'hFFFF), .DEPTH(256)) dut_w (
    .clk(clk), .rst(rst), .start(start), .bus(wif),
    .cpu_hold(cpu_hold_w), .done(done_w), .err(err_w)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned start_cyc = 0;
  logic [47:0] sb_b[$];
  logic [47:0] sb_w[$];
  logic        last_acc_b = 1'b0;
  logic        last_acc_w = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    last_acc_b <= bif.byte_valid && bif.byte_ready;
    last_acc_w <= wif.byte_valid && wif.byte_ready;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write monitors: each strobe must follow a byte accept and match the queue
  always @(negedge clk) begin
    if (bif.wr_en) begin
      chk("b_wr_after_accept", 32'(last_acc_b), 32'd1);
      chk("b_ready_in_write", 32'(bif.byte_ready), 32'd0);
      if (sb_b.size() == 0) chk("b_wr_unexpected", 32'd1, 32'd0);
      else begin
        logic [47:0] e;
        e = sb_b.pop_front();
        chk("b_wr_addr", 32'(bif.wr_addr), 32'(e[47:32]));
        chk("b_wr_data", bif.wr_data, e[31:0]);
      end
    end
    if (wif.wr_en) begin
      chk("w_wr_after_accept", 32'(last_acc_w), 32'd1);
      if (sb_w.size() == 0) chk("w_wr_unexpected", 32'd1, 32'd0);
      else begin
        logic [47:0] e;
        e = sb_w.pop_front();
        chk("w_wr_addr", 32'(wif.wr_addr), 32'(e[47:32]));
        chk("w_wr_data", wif.wr_data, e[31:0]);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] b);
    bif.byte_valid = v; wif.byte_valid = v;
    bif.byte_in    = b; wif.byte_in    = b;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input int unsigned gapmax, input bit pulse_start);
    int tries = 0;
    repeat ($urandom_range(gapmax, 0)) begin
      drive(1'b0, 8'h00);
      @(negedge clk);
    end
    drive(1'b1, b);
    if (pulse_start) start = 1'b1;
    while (!bif.byte_ready && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 40) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00);
    start = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int unsigned gapmax,
                           input bit pulse_start);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        sb_b.push_back({16'(32'h0000 + idx), w});
        sb_w.push_back({16'(32'hFFFF + idx), w});
      end
      send_byte(w[31-8*i -: 8], gapmax, pulse_start && (i == 1));
    end
  endtask

  task automatic do_start(input bit with_valid);
    @(negedge clk);
    start = 1'b1;
    if (with_valid) drive(1'b1, 8'hA5);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    drive(1'b0, 8'h00);
    chk("start_hold", 32'(cpu_hold_b), 32'd1);
    chk("start_ready", 32'(bif.byte_ready), 32'd1);
    chk("start_done_clr", 32'(done_b), 32'd0);
    chk("start_err_clr", 32'(err_b), 32'd0);
  endtask

  task automatic wait_end(output int cycles);
    int tries = 0;
    while (!(done_b || err_b) && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) chk("end_timeout", 32'd0, 32'd1);
    cycles = int'(cyc - start_cyc) + 1;
  endtask

  task automatic load(input logic [15:0] n, input logic [31:0] words[$], input int unsigned gapmax,
                      input bit mid_start, input bit with_valid, output int cycles);
    do_start(with_valid);
    send_byte(n[15:8], gapmax, 1'b0);
    send_byte(n[7:0], gapmax, 1'b0);
    if (n != 16'd0 && n <= 16'd256)
      for (int i = 0; i < int'(n); i++) send_word(i, words[i], gapmax, mid_start && (i == 0));
    wait_end(cycles);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bif.byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(bif.wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bif.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, bif.wr_data, 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold_b), 32'd0);
    chk({tag, "_done"}, 32'(done_b), 32'd0);
    chk({tag, "_err"}, 32'(err_b), 32'd0);
    chk({tag, "_w_hold"}, 32'(cpu_hold_w), 32'd0);
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] big[$];
    int cycles;

    rst = 1'b1;
    start = 1'b0;
    drive(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Basic load, byte_valid high throughout
    words = '{32'h12345678, 32'h9ABCDEF0};
    load(16'd2, words, 0, 1'b0, 1'b0, cycles);
    chk("basic_cycles", 32'(cycles), 32'd14);
    chk("basic_done", 32'(done_b), 32'd1);
    chk("basic_hold", 32'(cpu_hold_b), 32'd0);
    chk("wrap_done", 32'(done_w), 32'd1);
    chk("basic_sb_empty", 32'(sb_b.size() + sb_w.size()), 32'd0);

    // Random gaps; each load restarts from DONE
    for (int r = 0; r < 3; r++) begin
      load(16'd2, words, 3, 1'b0, 1'b0, cycles);
      chk("gap_done", 32'(done_b), 32'd1);
      chk("gap_hold", 32'(cpu_hold_b), 32'd0);
    end

    // start pulsed during DATA, and start together with byte_valid from DONE
    words = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h00000001};
    load(16'd3, words, 1, 1'b1, 1'b1, cycles);
    chk("midstart_done", 32'(done_b), 32'd1);
    chk("midstart_sb_empty", 32'(sb_b.size() + sb_w.size()), 32'd0);

    // Zero length
    load(16'd0, words, 0, 1'b0, 1'b0, cycles);
    chk("zero_done", 32'(done_b), 32'd1);
    chk("zero_err", 32'(err_b), 32'd0);
    chk("zero_hold", 32'(cpu_hold_b), 32'd0);
    chk("zero_ready", 32'(bif.byte_ready), 32'd0);

    // Oversize length
    load(16'h0101, words, 0, 1'b0, 1'b0, cycles);
    chk("over_err", 32'(err_b), 32'd1);
    chk("over_done", 32'(done_b), 32'd0);
    chk("over_hold", 32'(cpu_hold_b), 32'd0);
    drive(1'b1, 8'h55);
    repeat (3) @(negedge clk);
    chk("over_ready_after", 32'(bif.byte_ready), 32'd0);
    chk("over_err_held", 32'(err_b), 32'd1);
    drive(1'b0, 8'h00);

    // Exactly DEPTH words
    for (int i = 0; i < 256; i++) big.push_back($urandom);
    load(16'd256, big, 0, 1'b0, 1'b0, cycles);
    chk("depth_done", 32'(done_b), 32'd1);
    chk("depth_err", 32'(err_b), 32'd0);
    chk("depth_sb_empty", 32'(sb_b.size() + sb_w.size()), 32'd0);

    // Reset after 6 data bytes of a 3-word load
    do_start(1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_word(0, 32'h11223344, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("midrst_sb_empty", 32'(sb_b.size() + sb_w.size()), 32'd0);
    words = '{32'hDEADBEEF};
    load(16'd1, words, 2, 1'b0, 1'b0, cycles);
    chk("after_rst_done", 32'(done_b), 32'd1);

    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(sb_b.size() + sb_w.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
